spike_event_packer: RTL and testbench

SPIKE_EVENT_PACKER -- requirements
Module: spike_event_packer

---
 rtl/spike_pkg.sv | 21 ++
 rtl/spike_fifo.sv | 51 +++++
 rtl/spike_event_packer.sv | 144 ++++++++++++++
 tb/tb_spike_event_packer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
// Shared defaults, event word layout and output FSM encoding for the spike event packer.
package spike_pkg;

  localparam int N_NEUR_D = 16;
  localparam int IDX_W_D  = 8;
  localparam int TS_W_D   = 16;
  localparam int FIFO_D_D = 8;

  // Event word as delivered to the serializer: timestamp in the upper field.
  typedef struct packed {
    logic [TS_W_D-1:0]  ts;
    logic [IDX_W_D-1:0] idx;
  } evt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_HOLD = 2'd2
  } out_state_e;

endpackage

// File: rtl/spike_fifo.sv
// Count-based synchronous event FIFO; read data is the head entry, valid while not empty.
module spike_fifo #(
  parameter int W = 24,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned DEPTH = D;

  logic [W-1:0]  mem_reg [D];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == DEPTH[AW:0]);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_reg[rd_ptr_reg];

  // Storage write; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= din;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (!do_push && do_pop) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/spike_event_packer.sv
// Captures a spike vector per timestep, serialises set bits into {timestamp, index}
// events through a FIFO, and hands them one at a time to a downstream serializer.
module spike_event_packer
  import spike_pkg::*;
#(
  parameter int N_NEUR = N_NEUR_D,
  parameter int IDX_W  = IDX_W_D,
  parameter int TS_W   = TS_W_D,
  parameter int FIFO_D = FIFO_D_D
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [N_NEUR-1:0]     spikes,
  input  logic                  ser_val,
  output logic                  wr,
  output logic [TS_W+IDX_W-1:0] data_out,
  output logic                  overrun,
  output logic                  fifo_full
);

  localparam int EVT_W = TS_W + IDX_W;

  logic              rst_meta_reg, rst_sync_reg, rst_n;
  logic [TS_W-1:0]   ts_cnt_reg, ts_cnt_next;
  logic [TS_W-1:0]   cur_ts_reg, cur_ts_next;
  logic [N_NEUR-1:0] pending_reg, pending_next;
  logic              overrun_reg, overrun_next;
  logic [N_NEUR-1:0] lowest_oh;
  logic [IDX_W-1:0]  enc_idx;
  logic              push, pop, fifo_empty;
  logic [EVT_W-1:0]  fifo_dout;
  out_state_e        state_reg, state_next;
  logic              wr_reg, wr_next;
  logic [EVT_W-1:0]  data_out_reg;

  // Reset asserts immediately, releases two clock edges after the pin goes high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta_reg <= 1'b0;
      rst_sync_reg <= 1'b0;
    end else begin
      rst_meta_reg <= 1'b1;
      rst_sync_reg <= rst_meta_reg;
    end
  end
  assign rst_n = rst_sync_reg;

  // Lowest set pending bit: as a one-hot mask for clearing and as a binary index.
  assign lowest_oh = pending_reg & (~pending_reg + 1'b1);
  always_comb begin
    enc_idx = '0;
    for (int i = N_NEUR - 1; i >= 0; i--) begin
      if (pending_reg[i]) enc_idx = IDX_W'(i);
    end
  end

  // A tick edge always wins over a push, so the bit that would have gone out is lost.
  assign push = (|pending_reg) && !fifo_full && !tick;

  // Capture, drain and overrun bookkeeping for the pending spike vector.
  always_comb begin
    ts_cnt_next  = ts_cnt_reg;
    cur_ts_next  = cur_ts_reg;
    pending_next = pending_reg;
    overrun_next = overrun_reg;
    if (tick) begin
      pending_next = spikes;
      cur_ts_next  = ts_cnt_reg;
      ts_cnt_next  = ts_cnt_reg + 1'b1;
      if (|pending_reg) overrun_next = 1'b1;
    end else if (push) begin
      pending_next = pending_reg & ~lowest_oh;
    end
  end

  // Capture-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_reg  <= '0;
      cur_ts_reg  <= '0;
      pending_reg <= '0;
      overrun_reg <= 1'b0;
    end else begin
      ts_cnt_reg  <= ts_cnt_next;
      cur_ts_reg  <= cur_ts_next;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
    end
  end

  spike_fifo #(
    .W (EVT_W),
    .D (FIFO_D)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({cur_ts_reg, enc_idx}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Output FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Output FSM transitions; HOLD gives the serializer time to raise ser_val.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (!fifo_empty && !ser_val) state_next = ST_WR;
      ST_WR:   state_next = ST_HOLD;
      ST_HOLD: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output FSM decode: pop the head on the IDLE -> WR transition.
  always_comb begin
    pop     = (state_reg == ST_IDLE) && !fifo_empty && !ser_val;
    wr_next = pop;
  end

  // Registered strobe and event word; data_out keeps the last word sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_reg       <= 1'b0;
      data_out_reg <= '0;
    end else begin
      wr_reg <= wr_next;
      if (pop) data_out_reg <= fifo_dout;
    end
  end

  assign wr       = wr_reg;
  assign data_out = data_out_reg;
  assign overrun  = overrun_reg;

endmodule

// File: tb/tb_spike_event_packer.sv
// Directed bench for spike_event_packer with a simple serializer model and event monitor.
module tb_spike_event_packer;
  import spike_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [15:0] spikes = '0;
  logic        ser_val = 1'b0;
  logic        wr;
  logic [23:0] data_out;
  logic        overrun;
  logic        fifo_full;

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] rx[$];
  logic hold_ser = 1'b0;
  int drain = 0;
  int drain_len = 3;

  spike_event_packer dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .spikes    (spikes),
    .ser_val   (ser_val),
    .wr        (wr),
    .data_out  (data_out),
    .overrun   (overrun),
    .fifo_full (fifo_full)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ev(input int ts, input int idx);
    evt_t e;
    e.ts  = ts[15:0];
    e.idx = idx[7:0];
    return e;
  endfunction

  // Serializer model: raises ser_val after each load and drains for drain_len cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (drain > 0) drain--;
      if (wr === 1'b1) drain = drain_len;
      ser_val = hold_ser || (drain > 0);
    end
  end

  // Event monitor: logs each load and checks strobe spacing against ser_val.
  initial begin
    logic prev_wr, prev_ser;
    prev_wr = 1'b0;
    prev_ser = 1'b0;
    forever begin
      @(negedge clk);
      if (wr === 1'b1) begin
        rx.push_back(data_out);
        vectors++;
        if (prev_wr === 1'b1 || prev_ser === 1'b1) begin
          miscompares++;
          $display("FAIL wr_spacing: wr=1 data=%h with prev wr=%b prev ser_val=%b, required both 0",
                   data_out, prev_wr, prev_ser);
        end
      end
      prev_wr = wr;
      prev_ser = ser_val;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_tick(input logic [15:0] spk);
    @(negedge clk);
    tick = 1'b1;
    spikes = spk;
    @(negedge clk);
    tick = 1'b0;
    spikes = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    vectors++;
    if (wr !== 1'b0 || data_out !== 24'h0 || overrun !== 1'b0 || fifo_full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: wr=%b data=%h ovr=%b full=%b, required 0 0 0 0",
               wr, data_out, overrun, fifo_full);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (wr !== 1'b0 || data_out !== 24'h0 || overrun !== 1'b0 || fifo_full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: wr=%b data=%h ovr=%b full=%b, required 0 0 0 0",
               wr, data_out, overrun, fifo_full);
    end
  endtask

  task automatic test_two_spikes();
    repeat (3) do_tick(16'h0000);
    rx.delete();
    do_tick(16'h0005);
    vectors++;
    if (wr !== 1'b0) begin miscompares++; $display("FAIL lat_e0: wr=%b, required 0", wr); end
    @(negedge clk);
    vectors++;
    if (wr !== 1'b0) begin miscompares++; $display("FAIL lat_e1: wr=%b, required 0", wr); end
    @(negedge clk);
    vectors++;
    if (wr !== 1'b1 || data_out !== 24'h000300) begin
      miscompares++;
      $display("FAIL lat_e2: wr=%b data=%h, required 1 000300", wr, data_out);
    end
    @(negedge clk);
    vectors++;
    if (wr !== 1'b0) begin miscompares++; $display("FAIL lat_e3: wr=%b, required 0", wr); end
    wait_rx(2, 60);
    vectors++;
    if (rx.size() != 2) begin
      miscompares++;
      $display("FAIL two_count: got %0d events, required 2", rx.size());
    end else begin
      vectors++;
      if (rx[0] !== 24'h000300 || rx[1] !== 24'h000302) begin
        miscompares++;
        $display("FAIL two_data: got %h %h, required 000300 000302", rx[0], rx[1]);
      end
    end
  endtask

  task automatic test_fifo_full();
    @(negedge clk);
    hold_ser = 1'b1;
    repeat (2) @(negedge clk);
    rx.delete();
    do_tick(16'h03FF);
    repeat (12) @(negedge clk);
    vectors++;
    if (fifo_full !== 1'b1 || overrun !== 1'b0 || rx.size() != 0) begin
      miscompares++;
      $display("FAIL full_hold: full=%b ovr=%b sent=%0d, required 1 0 0", fifo_full, overrun, rx.size());
    end
    vectors++;
    if (dut.pending_reg !== 16'h0300) begin
      miscompares++;
      $display("FAIL full_pending: pending=%h, required 0300", dut.pending_reg);
    end
    hold_ser = 1'b0;
    wait_rx(10, 200);
    vectors++;
    if (rx.size() != 10) begin
      miscompares++;
      $display("FAIL full_count: got %0d events, required 10", rx.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        vectors++;
        if (rx[i] !== ev(4, i)) begin
          miscompares++;
          $display("FAIL full_data[%0d]: got %h, required %h", i, rx[i], ev(4, i));
        end
      end
    end
    vectors++;
    if (fifo_full !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL full_after: full=%b ovr=%b, required 0 0", fifo_full, overrun);
    end
  endtask

  task automatic test_overrun();
    int exp_ts[6];
    int exp_ix[6];
    exp_ts = '{5, 5, 5, 5, 6, 6};
    exp_ix = '{0, 1, 2, 3, 0, 1};
    rx.delete();
    do_tick(16'hFFFF);
    repeat (4) @(negedge clk);
    tick = 1'b1;
    spikes = 16'h0003;
    @(negedge clk);
    tick = 1'b0;
    spikes = '0;
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_flag: overrun=%b, required 1", overrun);
    end
    wait_rx(6, 200);
    repeat (20) @(negedge clk);
    vectors++;
    if (rx.size() != 6) begin
      miscompares++;
      $display("FAIL ovr_count: got %0d events, required 6", rx.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (rx[i] !== ev(exp_ts[i], exp_ix[i])) begin
          miscompares++;
          $display("FAIL ovr_data[%0d]: got %h, required %h", i, rx[i], ev(exp_ts[i], exp_ix[i]));
        end
      end
    end
  endtask

  task automatic test_ts_wrap();
    do_reset();
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_reset_ovr: overrun=%b, required 0", overrun);
    end
    rx.delete();
    @(negedge clk);
    tick = 1'b1;
    spikes = '0;
    repeat (65536) @(negedge clk);
    tick = 1'b0;
    vectors++;
    if (rx.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_quiet: got %0d events, required 0", rx.size());
    end
    do_tick(16'h8000);
    wait_rx(1, 40);
    vectors++;
    if (rx.size() != 1) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d events, required 1", rx.size());
    end else begin
      vectors++;
      if (rx[0] !== 24'h00000F) begin
        miscompares++;
        $display("FAIL wrap_data: got %h, required 00000f", rx[0]);
      end
    end
  endtask

  task automatic test_reset_mid_wr();
    int k;
    rx.delete();
    do_tick(16'h000F);
    k = 0;
    while (wr !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (wr !== 1'b1) begin
      miscompares++;
      $display("FAIL rstwr_reach: wr=%b, required 1", wr);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (wr !== 1'b0 || data_out !== 24'h0 || fifo_full !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL rstwr_clear: wr=%b data=%h full=%b ovr=%b, required 0 000000 0 0",
               wr, data_out, fifo_full, overrun);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    rx.delete();
    repeat (30) @(negedge clk);
    vectors++;
    if (rx.size() != 0) begin
      miscompares++;
      $display("FAIL rstwr_empty: got %0d events after reset, required 0", rx.size());
    end
    do_tick(16'h0004);
    wait_rx(1, 40);
    vectors++;
    if (rx.size() != 1) begin
      miscompares++;
      $display("FAIL rstwr_count: got %0d events, required 1", rx.size());
    end else begin
      vectors++;
      if (rx[0] !== 24'h000002) begin
        miscompares++;
        $display("FAIL rstwr_data: got %h, required 000002", rx[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [23:0] exp[$];
    logic [15:0] spk;
    int ts_m;
    ts_m = 1;
    rx.delete();
    for (int r = 0; r < 12; r++) begin
      spk = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'hFFFF));
      drain_len = $urandom_range(1, 6);
      do_tick(spk);
      for (int b = 0; b < 16; b++) begin
        if (spk[b]) exp.push_back(ev(ts_m, b));
      end
      ts_m++;
      wait_rx(exp.size(), 400);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (rx.size() != exp.size()) begin
      miscompares++;
      $display("FAIL rand_count: got %0d events, required %0d", rx.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        vectors++;
        if (rx[i] !== exp[i]) begin
          miscompares++;
          $display("FAIL rand_data[%0d]: got %h, required %h", i, rx[i], exp[i]);
        end
      end
    end
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL rand_ovr: overrun=%b, required 0", overrun);
    end
  endtask

  initial begin
    test_reset();
    test_two_spikes();
    test_fifo_full();
    test_overrun();
    test_ts_wrap();
    test_reset_mid_wr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
